// File: rtl/accelerator_transformer_layer_scheduler.sv
// Sequences MHA -> NORM1 -> FNN -> NORM2 stage starts for each transformer layer,
// tracks the layer index and flags completion strobes that arrive out of turn.
module accelerator_transformer_layer_scheduler #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [DATA_SIZE-1:0]    SIZE_L_IN,
  output logic                    MHA_START,
  output logic                    NORM1_START,
  output logic                    FNN_START,
  output logic                    NORM2_START,
  input  logic                    MHA_READY,
  input  logic                    NORM1_READY,
  input  logic                    FNN_READY,
  input  logic                    NORM2_READY,
  output logic [DATA_SIZE-1:0]    LAYER_OUT,
  output logic [CONTROL_SIZE-1:0] STAGE_OUT,
  output logic                    BUSY,
  output logic                    ERROR
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MHA   = 3'd1,
    S_NORM1 = 3'd2,
    S_FNN   = 3'd3,
    S_NORM2 = 3'd4
  } state_t;

  state_t               state;
  logic [DATA_SIZE-1:0] size_lat;
  logic [3:0]           stage_mask;
  logic [3:0]           ready_vec;
  logic [3:0]           start_vec;
  logic [3:0]           acc_vec;
  logic                 accept;
  logic                 violation;
  logic                 last_layer;

  always_comb begin
    stage_mask = 4'b0000;
    case (state)
      S_MHA:   stage_mask = 4'b0001;
      S_NORM1: stage_mask = 4'b0010;
      S_FNN:   stage_mask = 4'b0100;
      S_NORM2: stage_mask = 4'b1000;
      default: stage_mask = 4'b0000;
    endcase
  end

  // A strobe is only accepted for the active stage once its start pulse has passed;
  // every other strobe, including one during the pulse cycle, is a violation.
  assign ready_vec  = {NORM2_READY, FNN_READY, NORM1_READY, MHA_READY};
  assign start_vec  = {NORM2_START, FNN_START, NORM1_START, MHA_START};
  assign acc_vec    = ready_vec & stage_mask & ~start_vec;
  assign accept     = |acc_vec;
  assign violation  = |(ready_vec & ~acc_vec);
  assign last_layer = (LAYER_OUT == size_lat - DATA_SIZE'(1));

  assign STAGE_OUT  = CONTROL_SIZE'(state);
  assign BUSY       = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= S_IDLE;
      size_lat    <= '0;
      LAYER_OUT   <= '0;
      READY       <= 1'b0;
      MHA_START   <= 1'b0;
      NORM1_START <= 1'b0;
      FNN_START   <= 1'b0;
      NORM2_START <= 1'b0;
      ERROR       <= 1'b0;
    end else begin
      READY       <= 1'b0;
      MHA_START   <= 1'b0;
      NORM1_START <= 1'b0;
      FNN_START   <= 1'b0;
      NORM2_START <= 1'b0;
      if (violation) ERROR <= 1'b1;
      case (state)
        S_IDLE: begin
          if (START) begin
            ERROR <= violation;
            if (SIZE_L_IN != '0) begin
              size_lat  <= SIZE_L_IN;
              LAYER_OUT <= '0;
              state     <= S_MHA;
              MHA_START <= 1'b1;
            end else begin
              READY <= 1'b1;
            end
          end
        end
        S_MHA: begin
          if (accept) begin
            state       <= S_NORM1;
            NORM1_START <= 1'b1;
          end
        end
        S_NORM1: begin
          if (accept) begin
            state     <= S_FNN;
            FNN_START <= 1'b1;
          end
        end
        S_FNN: begin
          if (accept) begin
            state       <= S_NORM2;
            NORM2_START <= 1'b1;
          end
        end
        S_NORM2: begin
          if (accept) begin
            if (last_layer) begin
              state <= S_IDLE;
              READY <= 1'b1;
            end else begin
              LAYER_OUT <= LAYER_OUT + DATA_SIZE'(1);
              state     <= S_MHA;
              MHA_START <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accelerator_transformer_layer_scheduler.sv
// Scoreboard bench: stimulus queues expected start/READY pulses, a negedge monitor compares them.
module tb_accelerator_transformer_layer_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic [63:0] size_l_in;
  logic        mha_start, norm1_start, fnn_start, norm2_start;
  logic        mha_ready, norm1_ready, fnn_ready, norm2_ready;
  logic [63:0] layer_out;
  logic [3:0]  stage_out;
  logic        busy;
  logic        error;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    logic [4:0]  pulses;
    logic        chk_layer;
    logic [63:0] layer;
  } ev_t;
  ev_t exp_q[$];

  accelerator_transformer_layer_scheduler dut (
    .CLK(clk), .RST(rst), .START(start), .READY(ready), .SIZE_L_IN(size_l_in),
    .MHA_START(mha_start), .NORM1_START(norm1_start), .FNN_START(fnn_start),
    .NORM2_START(norm2_start), .MHA_READY(mha_ready), .NORM1_READY(norm1_ready),
    .FNN_READY(fnn_ready), .NORM2_READY(norm2_ready), .LAYER_OUT(layer_out),
    .STAGE_OUT(stage_out), .BUSY(busy), .ERROR(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // Monitor: every start/READY pulse must match the next queued expectation.
  always @(negedge clk) begin
    logic [4:0] act;
    ev_t e;
    act = {ready, norm2_start, fnn_start, norm1_start, mha_start};
    if (|act) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_pulse actual=%b expected=none", act);
      end else begin
        e = exp_q.pop_front();
        check("pulse", 64'(act), 64'(e.pulses));
        if (e.chk_layer) check("layer", layer_out, e.layer);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_stage(input int k, input logic [63:0] l);
    ev_t e;
    e.pulses = 5'(1 << k);
    e.chk_layer = 1'b1;
    e.layer = l;
    exp_q.push_back(e);
  endtask

  task automatic push_ready();
    ev_t e;
    e.pulses = 5'b10000;
    e.chk_layer = 1'b0;
    e.layer = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_layers(input int n);
    for (int l = 0; l < n; l++)
      for (int k = 0; k < 4; k++) push_stage(k, 64'(l));
  endtask

  function automatic logic pulse_of(input int k);
    case (k)
      0: return mha_start;
      1: return norm1_start;
      2: return fnn_start;
      3: return norm2_start;
      default: return ready;
    endcase
  endfunction

  task automatic set_rdy(input int k, input logic v);
    case (k)
      0: mha_ready = v;
      1: norm1_ready = v;
      2: fnn_ready = v;
      default: norm2_ready = v;
    endcase
  endtask

  task automatic wait_for(input int k);
    for (int i = 0; i < 100 && pulse_of(k) !== 1'b1; i++) @(negedge clk);
    if (pulse_of(k) !== 1'b1) begin
      chk_cnt++;
      $display("FAIL timeout_pulse%0d actual=0 expected=1", k);
    end
  endtask

  task automatic serve_stage(input int k, input int d);
    wait_for(k);
    tick(d);
    set_rdy(k, 1'b1);
    tick(1);
    set_rdy(k, 1'b0);
  endtask

  task automatic serve_layers(input int n, input int d);
    for (int l = 0; l < n; l++)
      for (int k = 0; k < 4; k++) serve_stage(k, d);
  endtask

  task automatic start_run(input logic [63:0] sz);
    size_l_in = sz;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulses"}, 64'({ready, norm2_start, fnn_start, norm1_start, mha_start}), 64'd0);
    check({tag, "_layer"}, layer_out, 64'd0);
    check({tag, "_stage"}, 64'(stage_out), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; size_l_in = '0;
    mha_ready = 1'b0; norm1_ready = 1'b0; fnn_ready = 1'b0; norm2_ready = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst = 1'b1;
    tick(2);

    // Two layers, strobes 3 cycles after each start
    push_layers(2); push_ready();
    start_run(64'd2);
    serve_layers(2, 3);
    wait_for(4);
    tick(1);
    check("run2_busy_after", 64'(busy), 64'd0);
    check("run2_error", 64'(error), 64'd0);
    check("run2_stage", 64'(stage_out), 64'd0);

    // Zero-length run
    push_ready();
    start_run(64'd0);
    check("zero_busy", 64'(busy), 64'd0);
    tick(3);
    check("zero_busy_later", 64'(busy), 64'd0);
    check("zero_stage", 64'(stage_out), 64'd0);

    // Out-of-turn FNN strobe during MHA
    push_layers(1); push_ready();
    start_run(64'd1);
    tick(1);
    fnn_ready = 1'b1; tick(1); fnn_ready = 1'b0;
    check("stray_error", 64'(error), 64'd1);
    check("stray_stage", 64'(stage_out), 64'd1);
    mha_ready = 1'b1; tick(1); mha_ready = 1'b0;
    serve_stage(1, 1); serve_stage(2, 1); serve_stage(3, 1);
    wait_for(4);
    check("stray_sticky", 64'(error), 64'd1);
    tick(1);
    push_layers(1); push_ready();
    start_run(64'd1);
    check("stray_cleared", 64'(error), 64'd0);
    serve_layers(1, 2);
    wait_for(4);
    tick(1);

    // MHA_READY in the same cycle as MHA_START
    push_layers(1); push_ready();
    start_run(64'd1);
    mha_ready = 1'b1; tick(1); mha_ready = 1'b0;
    check("early_error", 64'(error), 64'd1);
    check("early_stage", 64'(stage_out), 64'd1);
    tick(3);
    check("early_hold", 64'(stage_out), 64'd1);
    mha_ready = 1'b1; tick(1); mha_ready = 1'b0;
    serve_stage(1, 1); serve_stage(2, 1); serve_stage(3, 1);
    wait_for(4);
    tick(1);

    // Reset during layer 1 FNN, then a fresh three-layer run
    push_layers(1); push_stage(0, 64'd1); push_stage(1, 64'd1); push_stage(2, 64'd1);
    start_run(64'd3);
    serve_layers(1, 3);
    serve_stage(0, 1); serve_stage(1, 1);
    wait_for(2);
    check("abort_layer", layer_out, 64'd1);
    rst = 1'b0;
    tick(1);
    check_all_zero("abort");
    rst = 1'b1;
    tick(5);
    check("abort_queue", 64'(exp_q.size()), 64'd0);
    push_layers(3); push_ready();
    start_run(64'd3);
    serve_layers(3, 1);
    wait_for(4);
    tick(1);

    // START held high, SIZE_L_IN changed mid-run
    push_layers(1); push_ready(); push_layers(5); push_ready();
    size_l_in = 64'd1; start = 1'b1;
    tick(1);
    size_l_in = 64'd5;
    serve_layers(1, 2);
    wait_for(4);
    wait_for(0);
    start = 1'b0;
    serve_layers(5, 1);
    wait_for(4);
    tick(3);
    check("final_busy", 64'(busy), 64'd0);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/accelerator_transformer_layer_scheduler.md
ACCELERATOR_TRANSFORMER_LAYER_SCHEDULER -- requirements
Module: accelerator_transformer_layer_scheduler

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, width of layer count and layer index.
REQ-002 SHALL have parameter CONTROL_SIZE, default 4, width of the stage code.
REQ-003 SHALL have port CLK  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port START  in  1  run request, sampled in IDLE only.
REQ-006 SHALL have port READY  out  1  one-cycle pulse: run complete.
REQ-007 SHALL have port SIZE_L_IN  in  DATA_SIZE  number of layers, latched on accepted START.
REQ-008 SHALL have ports MHA_START, NORM1_START, FNN_START, NORM2_START  out  1 each  one-cycle stage start pulses.
REQ-009 SHALL have ports MHA_READY, NORM1_READY, FNN_READY, NORM2_READY  in  1 each  stage completion strobes.
REQ-010 SHALL have port LAYER_OUT  out  DATA_SIZE  current layer index, 0-based.
REQ-011 SHALL have port STAGE_OUT  out  CONTROL_SIZE  current state code.
REQ-012 SHALL have port BUSY  out  1  high in any state other than IDLE.
REQ-013 SHALL have port ERROR  out  1  sticky protocol-violation flag.

Function
REQ-014 SHALL implement FSM states, STAGE_OUT codes: IDLE=0, MHA=1, NORM1=2, FNN=3, NORM2=4.
REQ-015 SHALL, in IDLE with START=1 and SIZE_L_IN/=0, latch SIZE_L_IN, set LAYER_OUT=0, clear ERROR, enter MHA next cycle.
REQ-016 SHALL, in IDLE with START=1 and SIZE_L_IN=0, stay IDLE, clear ERROR, pulse READY on the next cycle, issue no stage START.
REQ-017 SHALL assert the stage's *_START for exactly the first cycle spent in that state (START sampled at edge t -> MHA_START high during cycle t+1).
REQ-018 SHALL accept the active stage's *_READY only from the cycle after its *_START pulse; READY in the pulse cycle counts as a violation (REQ-022).
REQ-019 SHALL, on accepted *_READY, advance MHA->NORM1->FNN->NORM2 in the next cycle; next stage START pulses that cycle.
REQ-020 SHALL, on accepted NORM2_READY: if LAYER_OUT = latched size-1, return IDLE and pulse READY the next cycle; else increment LAYER_OUT and enter MHA.
REQ-021 SHALL wait indefinitely in a stage for its *_READY; no timeout.
REQ-022 SHALL set ERROR when any *_READY is high and is not an accepted strobe of the active stage (including any *_READY in IDLE); ERROR holds until next accepted START or reset; FSM unaffected.
REQ-023 SHALL ignore START while BUSY=1; SIZE_L_IN changes after latching SHALL not affect the run.
REQ-024 SHALL treat the latched count as unsigned DATA_SIZE; LAYER_OUT never exceeds size-1 and never wraps.
REQ-025 SHALL drive READY and all *_START registered, never combinationally from inputs.

Reset
REQ-026 SHALL, while RST=0 at a rising edge, force IDLE, LAYER_OUT=0, STAGE_OUT=0, READY=0, BUSY=0, ERROR=0, all *_START=0, latched count=0.
REQ-027 SHALL abort any run when reset mid-operation; no READY pulse; first run after RST=1 requires a new START.

Verification
REQ-028 SIZE_L_IN=2, START 1 cycle, each *_READY returned 3 cycles after its START -> start pulse order MHA,NORM1,FNN,NORM2 x2; LAYER_OUT 0 then 1; one READY pulse; BUSY low after; ERROR=0.
REQ-029 SIZE_L_IN=0, START -> READY pulse next cycle, no *_START, BUSY stays 0.
REQ-030 SIZE_L_IN=1, FNN_READY injected during MHA -> ERROR=1 sticky, sequence completes normally; next START clears ERROR.
REQ-031 SIZE_L_IN=3, RST=0 during layer 1 FNN -> next cycle all outputs 0, STAGE_OUT=0; no READY; fresh START runs 3 layers from LAYER_OUT=0.
REQ-032 SIZE_L_IN=1, START held high throughout and SIZE_L_IN changed to 5 mid-run -> exactly 1 layer, one READY, then a new run starts (START still high) latching 5.
REQ-033 MHA_READY asserted in the same cycle as MHA_START -> ERROR=1, FSM stays MHA until a later MHA_READY.
